// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the program-load-and-run sequencer: FSM state encoding,
// the pipelined_datapath opcode map and instruction field positions.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StRead  = 3'd3,
        StCheck = 3'd4,
        StDone  = 3'd5
    } seq_state_e;

    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0100;
    localparam logic [3:0] OpInc  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0111;
    localparam logic [3:0] OpJ    = 4'b1000;
    localparam logic [3:0] OpBrn  = 4'b1011;
    localparam logic [3:0] OpLd   = 4'b1110;
    localparam logic [3:0] OpSvpc = 4'b1111;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 28;
    localparam int unsigned RdMsb     = 27;
    localparam int unsigned RdLsb     = 22;
    localparam int unsigned RsMsb     = 21;
    localparam int unsigned RsLsb     = 16;
    localparam int unsigned RtMsb     = 15;
    localparam int unsigned RtLsb     = 10;

    // Assemble one instruction word; the low 10 bits carry an immediate / jump target.
    function automatic logic [31:0] make_instr(input logic [3:0] op, input logic [5:0] rd,
                                               input logic [5:0] rs, input logic [5:0] rt,
                                               input logic [9:0] imm);
        logic [31:0] w;
        w = '0;
        w[OpcodeMsb:OpcodeLsb] = op;
        w[RdMsb:RdLsb]         = rd;
        w[RsMsb:RsLsb]         = rs;
        w[RtMsb:RtLsb]         = rt;
        w[9:0]                 = imm;
        return w;
    endfunction

    function automatic logic [3:0] instr_opcode(input logic [31:0] w);
        return w[OpcodeMsb:OpcodeLsb];
    endfunction

endpackage

// File: rtl/cpu_test_sequencer_if.sv
// Bus bundle between the sequencer and its environment: program load stream,
// instruction-memory write port, CPU reset/PC and register-file debug port.
interface cpu_test_sequencer_if #(
    parameter int unsigned IW = 32,
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 6
);
    logic          ld_valid;
    logic          ld_ready;
    logic [IW-1:0] ld_data;

    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;

    logic          cpu_rst;
    logic [AW-1:0] cpu_pc;

    logic [RW-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;

    // Sequencer side.
    modport master (
        input  ld_valid, ld_data, cpu_pc, dbg_rdata,
        output ld_ready, imem_we, imem_addr, imem_wdata, cpu_rst, dbg_raddr
    );

    // Host / CPU side.
    modport slave (
        output ld_valid, ld_data, cpu_pc, dbg_rdata,
        input  ld_ready, imem_we, imem_addr, imem_wdata, cpu_rst, dbg_raddr
    );

endinterface

// File: rtl/seq_halt_detect.sv
// Halt detector: counts consecutive enabled cycles with pc == halt_pc and flags
// halt on the cycle the run reaches HALT_HOLD, giving the pipeline time to drain.
module seq_halt_detect #(
    parameter int unsigned AW        = 8,
    parameter int unsigned HALT_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] halt_pc,
    output logic          halt
);

    localparam int unsigned HW = $clog2(HALT_HOLD + 1);
    localparam logic [HW-1:0] HoldMax = HW'(HALT_HOLD);

    logic [HW-1:0] hold_q, hold_d;
    logic          match;

    assign match = enable && (pc == halt_pc);

    // Next run length: reset on mismatch, saturate at HALT_HOLD.
    always_comb begin
        hold_d = hold_q;
        if (clear) begin
            hold_d = '0;
        end else if (enable) begin
            if (!match) begin
                hold_d = '0;
            end else if (hold_q != HoldMax) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign halt = match && !clear && (hold_d == HoldMax);

    // Run-length register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/cpu_test_sequencer.sv
// Program-load-and-run controller for pipelined_datapath: streams a program into
// imem with the CPU held in reset, runs it until halt (PC hold) or cycle budget,
// reads one register through the debug port and reports pass/fail.
// Optional PC signature: define SEQ_PC_SIG_EN.
module cpu_test_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned IW        = 32,
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned RW        = 6,
    parameter int unsigned CW        = 16,
    parameter int unsigned HALT_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [AW:0]                 load_len,
    input  logic [AW-1:0]               halt_pc,
    input  logic [CW-1:0]               max_cycles,
    input  logic [RW-1:0]               result_reg,
    input  logic [DW-1:0]               expected,
    cpu_test_sequencer_if.master        bus,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [DW-1:0]               result,
    output logic [CW-1:0]               cycle_count,
    output logic [31:0]                 pc_sig
);

    // Longest program that fits imem; larger load_len is clamped so addresses never wrap.
    localparam logic [AW:0] MaxWords = {1'b1, {AW{1'b0}}};

    seq_state_e state_q, state_d;

    logic          capture;
    logic          load_hs;
    logic          run_active;
    logic          halt_hit;
    logic          timeout_hit;

    logic [AW:0]   len_q;
    logic [AW:0]   word_cnt_q;
    logic [AW-1:0] halt_pc_q;
    logic [CW-1:0] max_q;
    logic [RW-1:0] result_reg_q;
    logic [DW-1:0] expected_q;
    logic [CW-1:0] cc_inc;

    logic          imem_we_q;
    logic [AW-1:0] imem_addr_q;
    logic [IW-1:0] imem_wdata_q;

    assign run_active  = (state_q == StRun);
    assign cc_inc      = (cycle_count == {CW{1'b1}}) ? cycle_count : cycle_count + 1'b1;
    // Compare against the post-increment count so max_cycles==0 expires on the first RUN cycle.
    assign timeout_hit = (cc_inc >= max_q);

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

    seq_halt_detect #(
        .AW        (AW),
        .HALT_HOLD (HALT_HOLD)
    ) u_halt_detect (
        .clk     (clk),
        .reset   (reset),
        .clear   (capture),
        .enable  (run_active),
        .pc      (bus.cpu_pc),
        .halt_pc (halt_pc_q),
        .halt    (halt_hit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        load_hs       = 1'b0;
        bus.cpu_rst   = 1'b1;
        bus.ld_ready  = 1'b0;
        bus.dbg_raddr = '0;
        done          = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    capture = 1'b1;
                    state_d = (load_len == '0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    load_hs = 1'b1;
                    if ((word_cnt_q + 1'b1) == len_q) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                bus.cpu_rst = 1'b0;
                if (halt_hit || timeout_hit) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                bus.cpu_rst   = 1'b0;
                bus.dbg_raddr = result_reg_q;
                state_d       = StCheck;
            end
            StCheck: begin
                bus.cpu_rst = 1'b0;
                state_d     = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Configuration capture, imem write port, run counters and verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= '0;
            word_cnt_q   <= '0;
            halt_pc_q    <= '0;
            max_q        <= '0;
            result_reg_q <= '0;
            expected_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cycle_count  <= '0;
            timeout      <= 1'b0;
            pass         <= 1'b0;
            result       <= '0;
        end else begin
            imem_we_q <= load_hs;
            if (capture) begin
                len_q        <= (load_len > MaxWords) ? MaxWords : load_len;
                halt_pc_q    <= halt_pc;
                max_q        <= max_cycles;
                result_reg_q <= result_reg;
                expected_q   <= expected;
                word_cnt_q   <= '0;
                cycle_count  <= '0;
                timeout      <= 1'b0;
                pass         <= 1'b0;
            end
            if (load_hs) begin
                imem_addr_q  <= word_cnt_q[AW-1:0];
                imem_wdata_q <= bus.ld_data;
                word_cnt_q   <= word_cnt_q + 1'b1;
            end
            if (run_active) begin
                cycle_count <= cc_inc;
                // A halt on the same cycle as budget expiry is a clean halt.
                if (halt_hit || timeout_hit) begin
                    timeout <= !halt_hit;
                end
            end
            if (state_q == StCheck) begin
                result <= bus.dbg_rdata;
                pass   <= (bus.dbg_rdata == expected_q) && !timeout;
            end
        end
    end

`ifdef SEQ_PC_SIG_EN
    // Rotate-XOR signature of the fetch PC over every RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_sig <= '0;
        end else if (capture) begin
            pc_sig <= '0;
        end else if (run_active) begin
            pc_sig <= {pc_sig[30:0], pc_sig[31]} ^ 32'(bus.cpu_pc);
        end
    end
`else
    assign pc_sig = '0;
`endif

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Scoreboard bench for cpu_test_sequencer: a CPU stand-in follows J instructions
// from the loaded imem, and its register file holds the values the programs leave.
module tb_cpu_test_sequencer;
    import cpu_seq_pkg::*;

    localparam int unsigned IW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 6;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic          pass;
        logic          timeout;
        logic [DW-1:0] result;
        logic [CW-1:0] cc;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   load_len;
    logic [AW-1:0] halt_pc;
    logic [CW-1:0] max_cycles;
    logic [RW-1:0] result_reg;
    logic [DW-1:0] expected;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [DW-1:0] result;
    logic [CW-1:0] cycle_count;
    logic [31:0]   pc_sig;

    cpu_test_sequencer_if #(.IW(IW), .AW(AW), .DW(DW), .RW(RW)) bus ();

    cpu_test_sequencer #(
        .IW(IW), .AW(AW), .DW(DW), .RW(RW), .CW(CW), .HALT_HOLD(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_len    (load_len),
        .halt_pc     (halt_pc),
        .max_cycles  (max_cycles),
        .result_reg  (result_reg),
        .expected    (expected),
        .bus         (bus),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .result      (result),
        .cycle_count (cycle_count),
        .pc_sig      (pc_sig)
    );

    always #5 clk = ~clk;

    // CPU stand-in: imem, a PC that follows J and otherwise steps, registered debug read.
    logic [IW-1:0] imem [0:(1<<AW)-1];
    logic [DW-1:0] rf   [0:(1<<RW)-1];
    logic [AW-1:0] pc;

    assign bus.cpu_pc = pc;

    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
        if (bus.cpu_rst) pc <= '0;
        else if (instr_opcode(imem[pc]) == OpJ) pc <= imem[pc][AW-1:0];
        else pc <= pc + 1'b1;
        bus.dbg_rdata <= rf[bus.dbg_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+IW-1:0] wr_q[$];
    res_t             res_q[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic void bound_expired(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    // Monitor: every imem write and every rising done is checked against the scoreboard.
    initial begin
        logic       done_prev;
        logic [AW+IW-1:0] ew;
        res_t       er;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    bound_expired("imem_we_unexpected");
                end else begin
                    ew = wr_q.pop_front();
                    check("imem_addr", 64'(bus.imem_addr), 64'(ew[AW+IW-1:IW]));
                    check("imem_wdata", 64'(bus.imem_wdata), 64'(ew[IW-1:0]));
                end
            end
            if (done === 1'b1 && !done_prev) begin
                if (res_q.size() == 0) begin
                    bound_expired("done_unexpected");
                end else begin
                    er = res_q.pop_front();
                    check("pass", 64'(pass), 64'(er.pass));
                    check("timeout", 64'(timeout), 64'(er.timeout));
                    check("result", 64'(result), 64'(er.result));
                    check("cycle_count", 64'(cycle_count), 64'(er.cc));
                end
            end
            done_prev = (done === 1'b1);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "/cpu_rst"}, 64'(bus.cpu_rst), 64'd1);
        check({tag, "/ld_ready"}, 64'(bus.ld_ready), 64'd0);
        check({tag, "/imem_we"}, 64'(bus.imem_we), 64'd0);
        check({tag, "/imem_addr"}, 64'(bus.imem_addr), 64'd0);
        check({tag, "/imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "/dbg_raddr"}, 64'(bus.dbg_raddr), 64'd0);
        check({tag, "/done"}, 64'(done), 64'd0);
        check({tag, "/pass_timeout"}, {62'd0, pass, timeout}, 64'd0);
        check({tag, "/result"}, 64'(result), 64'd0);
        check({tag, "/cycle_count"}, 64'(cycle_count), 64'd0);
        check({tag, "/pc_sig"}, 64'(pc_sig), 64'd0);
    endtask

    task automatic do_start(input int len, input logic [AW-1:0] hpc, input logic [CW-1:0] maxc,
                            input logic [RW-1:0] rreg, input logic [DW-1:0] expv,
                            input bit push, input res_t er);
        load_len   = (AW+1)'(len);
        halt_pc    = hpc;
        max_cycles = maxc;
        result_reg = rreg;
        expected   = expv;
        if (push) res_q.push_back(er);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word after `gaps` idle cycles; returns just after the handshake edge.
    task automatic send_word(input logic [AW-1:0] addr, input logic [IW-1:0] w, input int gaps);
        int n;
        repeat (gaps) begin
            bus.ld_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = w;
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ld_ready !== 1'b1) bound_expired("ld_ready_wait");
        else wr_q.push_back({addr, w});
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) bound_expired("done_wait");
    endtask

    task automatic wait_run(input int limit);
        int n;
        n = 0;
        while (bus.cpu_rst !== 1'b0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.cpu_rst !== 1'b0) bound_expired("run_wait");
    endtask

    initial begin
        logic [3:0] ops [7];
        ops = '{OpAdd, OpInc, OpSub, OpLd, OpBrn, OpSvpc, OpNop};
        for (int i = 0; i < (1 << AW); i++) imem[i] = '0;
        for (int i = 0; i < (1 << RW); i++) rf[i] = 32'(i * 3 + 100);
        rf[1]  = 32'h0000_1234;
        rf[2]  = 32'd7;
        rf[3]  = 32'd5;
        rf[4]  = 32'd9;
        rf[10] = 32'd3;   // minimum of the min-search data set {17,42,9,88,23,3,61}

        reset = 1'b1; start = 1'b0; load_len = '0; halt_pc = '0; max_cycles = '0;
        result_reg = '0; expected = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Min-search: 29 words, self-loop at 0x1C; PC hits 0x1C on RUN cycle 29, halts on 32.
        do_start(29, 8'h1C, 16'd200, 6'd10, 32'd3, 1'b1, '{1'b1, 1'b0, 32'd3, 16'd32});
        for (int i = 0; i < 28; i++)
            send_word(AW'(i), make_instr(ops[i % 7], 6'(i), 6'(i + 1), 6'(i + 2), 10'(i)), 0);
        send_word(8'h1C, make_instr(OpJ, 6'd0, 6'd0, 6'd0, 10'h1C), 0);
        wait_done(400);

        // Infinite loop 0x08..0x15 never reaches 0x3F; start mid-RUN must be ignored.
        do_start(22, 8'h3F, 16'd50, 6'd1, 32'h1234, 1'b1, '{1'b0, 1'b1, 32'h1234, 16'd50});
        for (int i = 0; i < 21; i++)
            send_word(AW'(i), make_instr(OpInc, 6'(i), 6'd0, 6'd0, 10'd0), 0);
        send_word(8'h15, make_instr(OpJ, 6'd0, 6'd0, 6'd0, 10'h08), 0);
        repeat (5) @(posedge clk);
        #1;
        halt_pc = 8'h08; load_len = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400);

        // Backpressure: valid pattern 1,0,0,1,... over 4 words; cpu_rst drops one cycle after last.
        do_start(4, 8'h03, 16'd100, 6'd2, 32'd7, 1'b1, '{1'b1, 1'b0, 32'd7, 16'd7});
        for (int i = 0; i < 4; i++) begin
            send_word(AW'(i), (i == 3) ? make_instr(OpJ, 6'd0, 6'd0, 6'd0, 10'd3)
                                       : make_instr(OpInc, 6'(i), 6'(i), 6'd0, 10'd0),
                      (i == 0) ? 0 : 2);
            check("bp_cpu_rst", 64'(bus.cpu_rst), (i == 3) ? 64'd0 : 64'd1);
        end
        wait_done(400);

        // Reset at RUN cycle 10 aborts; then load_len==0 goes straight to RUN.
        do_start(5, 8'h3F, 16'd200, 6'd3, 32'd5, 1'b0, '0);
        for (int i = 0; i < 5; i++)
            send_word(AW'(i), (i == 4) ? make_instr(OpJ, 6'd0, 6'd0, 6'd0, 10'd4)
                                       : make_instr(OpAdd, 6'(i), 6'd1, 6'd2, 10'd0), 0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrun");
        @(posedge clk); #1;
        reset = 1'b0;
        do_start(0, 8'h04, 16'd200, 6'd3, 32'd5, 1'b1, '{1'b1, 1'b0, 32'd5, 16'd8});
        check("len0_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        check("len0_ld_ready", 64'(bus.ld_ready), 64'd0);
        wait_done(400);

        // Mismatch, started from DONE: status clears on the restart cycle.
        do_start(0, 8'h04, 16'd200, 6'd3, 32'hDEAD_BEEF, 1'b1, '{1'b0, 1'b0, 32'd5, 16'd8});
        check("restart_done", 64'(done), 64'd0);
        check("restart_cycle_count", 64'(cycle_count), 64'd0);
        check("restart_pc_sig", 64'(pc_sig), 64'd0);
        check("restart_pass", 64'(pass), 64'd0);
        wait_done(400);

        // Halt and budget expire on the same cycle: halt wins.
        do_start(0, 8'h04, 16'd8, 6'd3, 32'd5, 1'b1, '{1'b1, 1'b0, 32'd5, 16'd8});
        wait_done(400);

        // Zero budget: timeout on the first RUN cycle.
        do_start(0, 8'h3F, 16'd0, 6'd3, 32'd5, 1'b1, '{1'b0, 1'b1, 32'd5, 16'd1});
        wait_done(400);

        // load_len 300 clamps to 256 words; ld_valid held high afterwards is ignored.
        do_start(300, 8'hFF, 16'd1000, 6'd4, 32'd9, 1'b1, '{1'b1, 1'b0, 32'd9, 16'd259});
        for (int i = 0; i < 255; i++)
            send_word(AW'(i), make_instr(ops[i % 7], 6'(i), 6'(i), 6'(i), 10'(i)), 0);
        send_word(8'hFF, make_instr(OpJ, 6'd0, 6'd0, 6'd0, 10'hFF), 0);
        check("sat_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hA5A5_A5A5;
        wait_run(10);
        wait_done(600);
        bus.ld_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("res_queue_empty", 64'(res_q.size()), 64'd0);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_test_sequencer.md
Name: cpu_test_sequencer

Overview:
- Synthesizable program-load-and-run controller for pipelined_datapath; parametrised successor of the fixed 50-cycle directed bench.
- Streams an N-word program into instruction memory with the CPU held in reset, then releases it.
- Detects halt by PC match or by cycle budget, reads one architectural register through a debug port, and reports pass/fail against an expected value.
- Sits between a host/ROM stream and the CPU's imem write port and register-file debug port.

Parameters:
IW, 32, instruction word width
AW, 8, instruction memory address width
DW, 32, register data width
RW, 6, register index width
CW, 16, cycle counter width
HALT_HOLD, 4, consecutive cycles PC must equal halt_pc (pipeline drain)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
start  in  1  begin sequence; sampled in IDLE or DONE only
load_len  in  AW+1  words to load, captured on start
halt_pc  in  AW  halt address, captured on start
max_cycles  in  CW  run budget, captured on start
result_reg  in  RW  register to check, captured on start
expected  in  DW  expected value, captured on start
ld_valid  in  1  program word valid
ld_ready  out  1  high in LOAD
ld_data  in  IW  program word
imem_we  out  1  imem write strobe
imem_addr  out  AW  imem write address
imem_wdata  out  IW  imem write data
cpu_rst  out  1  CPU reset, active-high
cpu_pc  in  AW  CPU fetch PC
dbg_raddr  out  RW  register-file debug read index
dbg_rdata  in  DW  debug read data, one-cycle latency
done  out  1  level, high in DONE
pass  out  1  valid when done
timeout  out  1  valid when done
result  out  DW  captured dbg_rdata
cycle_count  out  CW  RUN cycles elapsed, saturating
pc_sig  out  32  PC signature (optional feature)

Behaviour:
- Reset values:
  - State is IDLE.
  - cpu_rst=1.
  - All other outputs are 0: ld_ready, imem_we, imem_addr, imem_wdata, dbg_raddr, done, pass, timeout, result, cycle_count, pc_sig.
- Reset asserted mid-operation aborts immediately to the same reset values; no partial imem writes after reset.
- States: IDLE, LOAD, RUN, READ, CHECK, DONE.
- IDLE:
  - cpu_rst=1.
  - start captures all configuration inputs and clears done, pass, timeout, cycle_count and the address counter.
  - Next state is LOAD, or RUN if load_len==0.
- LOAD:
  - ld_ready=1 and cpu_rst=1.
  - Each ld_valid&&ld_ready cycle writes imem at addr_cnt (imem_we, imem_addr, imem_wdata all registered, one cycle after the handshake).
  - addr_cnt increments by 1 per handshake. ld_valid low stalls with no write.
  - After the load_len-th handshake, go to RUN. load_len above 2^AW saturates at 2^AW words, with no address wrap.
  - ld_valid outside LOAD is ignored.
- RUN:
  - cpu_rst=0 from the first RUN cycle.
  - cycle_count increments each cycle and saturates at 2^CW-1.
  - The halt detector counts consecutive cycles with cpu_pc==halt_pc and clears on mismatch.
  - Count reaching HALT_HOLD sets halt. Otherwise cycle_count reaching max_cycles sets timeout=1.
  - If both occur on the same cycle, halt wins and timeout=0.
  - max_cycles==0 means timeout on the first RUN cycle.
  - Next state is READ.
- READ: dbg_raddr=result_reg for one cycle; CPU keeps running (spinning in halt loop).
- CHECK:
  - result<=dbg_rdata.
  - pass<=(dbg_rdata==expected)&&!timeout.
  - Next state is DONE.
- DONE:
  - done=1, cpu_rst=1; outputs hold.
  - start restarts exactly as from IDLE, with the same capture behaviour.
- start in LOAD, RUN, READ or CHECK is ignored.
- Latency from last load handshake to cpu_rst deassert: 1 cycle.

Optional Feature:
- Macro SEQ_PC_SIG_EN.
- Defined:
  - pc_sig is cleared on start.
  - Each RUN cycle, pc_sig <= {pc_sig[30:0],pc_sig[31]} ^ zero-extended cpu_pc.
  - pc_sig holds in READ, CHECK and DONE.
- Undefined: pc_sig is tied to 0 and no signature logic is generated.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state enum (6 states, 3-bit);
  - ISA constants: opcode codes NOP=0000, ADD=0100, INC=0101, SUB=0111, J=1000, BRN=1011, LD=1110, SVPC=1111;
  - field positions: opcode[31:28], rd[27:22], rs[21:16], rt[15:10].
- One sub-module, seq_halt_detect: PC compare plus HALT_HOLD counter, with a halt output.

Test Plan:
1. Min-search program:
   - Stimulus: load_len=29, halt_pc=0x1C, result_reg=10, expected=min of data memory, max_cycles=200.
   - Required: 29 imem writes at 0x00..0x1C, done with pass=1, timeout=0.
2. Infinite loop:
   - Stimulus: program "J x15" to 0x08 with halt_pc=0x3F and max_cycles=50.
   - Required: timeout=1, pass=0, cycle_count=50.
3. Load backpressure:
   - Stimulus: ld_valid toggled 1,0,0,1,… over 4 words.
   - Required: exactly 4 imem_we pulses at addresses 0..3; cpu_rst stays 1 until the cycle after the 4th handshake.
4. Reset mid-RUN:
   - Stimulus: assert reset at RUN cycle 10.
   - Required: same cycle, async return to all reset values and cpu_rst=1. A subsequent start with load_len=0 goes straight to RUN.
5. Mismatch:
   - Stimulus: expected=0xDEADBEEF against actual 5.
   - Required: result=5, pass=0, timeout=0.
6. Restart from DONE:
   - Stimulus: second start.
   - Required: done drops the next cycle, cycle_count=0, and (SEQ_PC_SIG_EN) pc_sig=0 before RUN.
